ram_arbiter: RTL and testbench

- Two-requester controller that sequences and shares one single_port_sync_ram instance (posedge write, negedge read latch, bidirectional data bus, cs/we/oe controls).
- Accepts one read or write request at a time, arbitrates round-robin, drives the RAM control pins and the shared data bus, and returns a one-cycle ack with read data.
- Sits between the CPU-side masters (e.g. fetch and load/store) and the RAM chip.

---
 rtl/ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_ram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin two-requester controller for one single-port synchronous RAM.
// Each granted access takes three cycles: IDLE (grant) -> ACCESS -> DONE (ack).
module ram_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  gnt_id, gnt_id_nxt;
  logic                  op_we, op_we_nxt;
  logic [DATA_WIDTH-1:0] op_wdata, op_wdata_nxt;
  logic                  last_grant, last_grant_nxt;
  logic                  ack0_nxt, ack1_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic                  busy_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic                  mem_cs_nxt, mem_we_nxt, mem_oe_nxt;

  logic                  any_req;
  logic                  winner;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // On a tie the requester that was not served last wins.
  always_comb begin
    any_req   = req0 | req1;
    winner    = (req0 && req1) ? ~last_grant : req1;
    sel_we    = winner ? we1    : we0;
    sel_addr  = winner ? addr1  : addr0;
    sel_wdata = winner ? wdata1 : wdata0;
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_nxt      = state;
    gnt_id_nxt     = gnt_id;
    op_we_nxt      = op_we;
    op_wdata_nxt   = op_wdata;
    last_grant_nxt = last_grant;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    rdata_nxt      = rdata;
    busy_nxt       = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_cs_nxt     = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_oe_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_id_nxt     = winner;
          op_we_nxt      = sel_we;
          op_wdata_nxt   = sel_wdata;
          last_grant_nxt = winner;
          mem_addr_nxt   = sel_addr;
          mem_cs_nxt     = 1'b1;
          mem_we_nxt     = sel_we;
          mem_oe_nxt     = ~sel_we;
          busy_nxt       = 1'b1;
          state_nxt      = ACCESS;
        end
      end
      ACCESS: begin
        // The RAM has been driving the bus since the mid-cycle negedge.
        if (!op_we) rdata_nxt = mem_data;
        ack0_nxt  = ~gnt_id;
        ack1_nxt  = gnt_id;
        busy_nxt  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt_id     <= 1'b0;
      op_we      <= 1'b0;
      op_wdata   <= '0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_oe     <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt_id     <= gnt_id_nxt;
      op_we      <= op_we_nxt;
      op_wdata   <= op_wdata_nxt;
      last_grant <= last_grant_nxt;
      ack0       <= ack0_nxt;
      ack1       <= ack1_nxt;
      rdata      <= rdata_nxt;
      busy       <= busy_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_cs     <= mem_cs_nxt;
      mem_we     <= mem_we_nxt;
      mem_oe     <= mem_oe_nxt;
    end
  end

  // The bus is released outside the ACCESS cycle of a write.
  assign mem_data = (state == ACCESS && op_we) ? op_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM on the shared bus, a transaction-level
// reference model checked every cycle, directed scenarios and random traffic.
module tb_ram_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs, mem_we, mem_oe;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  // Single-port RAM: posedge write, negedge read latch, drives bus when cs&oe.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  always @(posedge clk) if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
  always @(negedge clk) if (mem_cs && !mem_we) ram_q <= ram[mem_addr];
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : {DW{1'bz}};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction, described by its age in
  // cycles since the grant edge (1 = bus cycle, 2 = acknowledge cycle).
  typedef struct {
    logic          id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          m_txn;
  int            m_age  = 0;
  logic          m_last = 1'b1;
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  logic [DW-1:0] e_rdata = '0;
  logic [AW-1:0] e_addr  = '0;
  int            cyc = 0;
  int            ack_log[$];
  int            ack_cyc[$];

  task automatic model_edge();
    logic w;
    if (rst) begin
      if (m_age == 1 && m_txn.we) m_mem[m_txn.addr] = m_txn.wdata;
      m_age   = 0;
      m_last  = 1'b1;
      e_rdata = '0;
      e_addr  = '0;
    end else if (m_age == 0) begin
      if (req0 || req1) begin
        w           = (req0 && req1) ? !m_last : req1;
        m_txn.id    = w;
        m_txn.we    = w ? we1 : we0;
        m_txn.addr  = w ? addr1 : addr0;
        m_txn.wdata = w ? wdata1 : wdata0;
        m_last      = w;
        e_addr      = m_txn.addr;
        m_age       = 1;
      end
    end else if (m_age == 1) begin
      if (m_txn.we) m_mem[m_txn.addr] = m_txn.wdata;
      else          e_rdata = m_mem[m_txn.addr];
      m_age = 2;
    end else begin
      m_age = 0;
    end
  endtask

  task automatic compare();
    cyc++;
    check("mem_cs",   mem_cs,   m_age == 1);
    check("mem_we",   mem_we,   m_age == 1 && m_txn.we);
    check("mem_oe",   mem_oe,   m_age == 1 && !m_txn.we);
    check("mem_addr", mem_addr, e_addr);
    check("busy",     busy,     m_age != 0);
    check("ack0",     ack0,     m_age == 2 && !m_txn.id);
    check("ack1",     ack1,     m_age == 2 && m_txn.id);
    check("rdata",    rdata,    e_rdata);
    check("one_ack",  ack0 & ack1, 1'b0);
    if (m_age == 1 && m_txn.we) check("mem_data_wr", mem_data, m_txn.wdata);
    if (ack0) begin ack_log.push_back(0); ack_cyc.push_back(cyc); end
    if (ack1) begin ack_log.push_back(1); ack_cyc.push_back(cyc); end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic set_req(input logic id, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else    begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  // One access from an idle controller; returns read data and edges to ack.
  task automatic do_req(input logic id, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd, output int lat);
    logic seen;
    seen = 1'b0; rd = '0; lat = 0;
    set_req(id, 1'b1, w, a, d);
    while (!seen && lat < 10) begin
      tick();
      lat++;
      if (id ? ack1 : ack0) begin seen = 1'b1; rd = rdata; end
    end
    check("ack_seen", seen, 1'b1);
    set_req(id, 1'b0, w, a, d);
    tick();
  endtask

  logic [AW-1:0] pool [16];

  task automatic new_req(input logic id);
    set_req(id, 1'b1, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)],
            DW'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [DW-1:0] rd, rd0, rd1;
    int            lat;

    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("idle_ack0", ack0, 1'b0);
    check("idle_ack1", ack1, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_cs", mem_cs, 1'b0);
    check("idle_rdata", rdata, 8'h00);
    check("idle_addr", mem_addr, 14'h0000);

    // Write 0xA5 to 0x010, then read it back.
    set_req(1'b0, 1'b1, 1'b1, 14'h010, 8'hA5);
    tick();
    check("wr_cs", mem_cs, 1'b1);
    check("wr_we", mem_we, 1'b1);
    check("wr_bus", mem_data, 8'hA5);
    tick();
    check("wr_cs_off", mem_cs, 1'b0);
    check("wr_ack0", ack0, 1'b1);
    set_req(1'b0, 1'b0, 1'b1, 14'h010, 8'hA5);
    tick();
    check("wr_ack_pulse", ack0, 1'b0);
    do_req(1'b0, 1'b0, 14'h010, 8'h00, rd, lat);
    check("rd_a5", rd, 8'hA5);
    check("rd_latency", lat, 2);

    // Tie straight after reset: requester 0 first, requester 1 three cycles later.
    do_req(1'b0, 1'b1, 14'h001, 8'h11, rd, lat);
    do_req(1'b1, 1'b1, 14'h002, 8'h22, rd, lat);
    rst = 1'b1; tick(); rst = 1'b0;
    ack_log.delete(); ack_cyc.delete();
    rd0 = '0; rd1 = '0;
    set_req(1'b0, 1'b1, 1'b0, 14'h001, 8'h00);
    set_req(1'b1, 1'b1, 1'b0, 14'h002, 8'h00);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ack0) begin rd0 = rdata; req0 = 1'b0; end
      if (ack1) begin rd1 = rdata; req1 = 1'b0; end
    end
    check("tie_acks", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      check("tie_first", ack_log[0], 0);
      check("tie_second", ack_log[1], 1);
      check("tie_gap", ack_cyc[1] - ack_cyc[0], 3);
    end
    check("tie_rd0", rd0, 8'h11);
    check("tie_rd1", rd1, 8'h22);

    // Both requesters hold req: grants alternate, acks three cycles apart.
    ack_log.delete(); ack_cyc.delete();
    set_req(1'b0, 1'b1, 1'b0, 14'h001, 8'h00);
    set_req(1'b1, 1'b1, 1'b0, 14'h002, 8'h00);
    for (int k = 0; k < 40 && ack_log.size() < 8; k++) tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) tick();
    check("fair_count", ack_log.size() >= 8, 1'b1);
    for (int k = 0; k < 8 && k < ack_log.size(); k++) begin
      check("fair_order", ack_log[k], k % 2);
      if (k > 0) check("fair_gap", ack_cyc[k] - ack_cyc[k-1], 3);
    end

    // Address extremes.
    do_req(1'b0, 1'b1, 14'h0000, 8'hFF, rd, lat);
    do_req(1'b1, 1'b1, 14'h3FFF, 8'h00, rd, lat);
    do_req(1'b0, 1'b0, 14'h0000, 8'h00, rd, lat);
    check("edge_lo", rd, 8'hFF);
    do_req(1'b1, 1'b0, 14'h3FFF, 8'h00, rd, lat);
    check("edge_hi", rd, 8'h00);

    // Reset while a read is in its bus cycle.
    set_req(1'b0, 1'b1, 1'b0, 14'h010, 8'h00);
    tick();
    check("rst_in_access", mem_cs, 1'b1);
    rst = 1'b1;
    req0 = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_ack0", ack0, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cs", mem_cs, 1'b0);
    check("rst_oe", mem_oe, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_addr", mem_addr, 14'h0000);
    tick();
    check("rst_no_ack", ack0, 1'b0);
    do_req(1'b1, 1'b0, 14'h002, 8'h00, rd, lat);
    check("post_rst_rd1", rd, 8'h22);
    ack_log.delete(); ack_cyc.delete();
    set_req(1'b0, 1'b1, 1'b0, 14'h001, 8'h00);
    set_req(1'b1, 1'b1, 1'b0, 14'h002, 8'h00);
    for (int k = 0; k < 10 && ack_log.size() < 1; k++) tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) tick();
    check("post_rst_tie", ack_log.size() >= 1 ? ack_log[0] : 9, 0);

    // Random traffic over a pool of addresses that are written first.
    pool[0] = 14'h0000; pool[1] = 14'h3FFF; pool[2] = 14'h0010; pool[3] = 14'h0001;
    pool[4] = 14'h0002;
    for (int i = 5; i < 16; i++) pool[i] = AW'($urandom_range(0, (1 << AW) - 1));
    for (int i = 0; i < 16; i++)
      do_req(1'(i % 2), 1'b1, pool[i], DW'($urandom_range(0, 255)), rd, lat);
    for (int c = 0; c < 2000; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        logic acked, active, granted;
        int   r;
        acked   = (i == 1) ? ack1 : ack0;
        active  = (i == 1) ? req1 : req0;
        granted = (m_age != 0) && (m_txn.id == 1'(i));
        if (acked) begin
          if ($urandom_range(0, 1) == 1) new_req(1'(i));
          else if (i == 1) req1 = 1'b0;
          else req0 = 1'b0;
        end else if (!active) begin
          if ($urandom_range(0, 3) == 0) new_req(1'(i));
        end else if (!granted) begin
          r = $urandom_range(0, 9);
          if (r == 0) begin
            if (i == 1) req1 = 1'b0; else req0 = 1'b0;
          end else if (r == 1) begin
            new_req(1'(i));
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
